kf76489_write_sequencer: RTL and testbench

//   Host-side register-write scheduler for the KF76489 bus control logic.
//   - Accepts register-write commands (register address + 10-bit value) on a valid/ready port.
//   - Buffers them in a small FIFO.
//   - Serialises each command into 1 or 2 SN76489-format bytes.
//   - Drives CE_N/WE_N/D_IN with programmable strobe width and recovery gap.
//   - Sits between a CPU/sequencer and the KF76489 bus port, so requesters never hand-time the bus.
//

---
 rtl/kf76489_pkg.sv | 49 ++++
 rtl/kf76489_cmd_fifo.sv | 55 +++++
 rtl/kf76489_write_sequencer.sv | 156 +++++++++++++++
 tb/tb_kf76489_write_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf76489_pkg.sv
// Shared types and byte-format helpers for the KF76489 write sequencer.
package kf76489_pkg;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned VALUE_W = 10;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ENTRY_W = ADDR_W + VALUE_W;

  localparam logic              LATCH_BIT = 1'b1;
  localparam logic [BYTE_W-1:0] BUS_IDLE  = 8'hFF;

  typedef enum logic [ADDR_W-1:0] {
    REG_T1_FREQ    = 3'b000,
    REG_T3_FREQ    = 3'b001,
    REG_T2_FREQ    = 3'b010,
    REG_NOISE_CTRL = 3'b011,
    REG_T1_ATT     = 3'b100,
    REG_T3_ATT     = 3'b101,
    REG_T2_ATT     = 3'b110,
    REG_NOISE_ATT  = 3'b111
  } reg_code_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [VALUE_W-1:0] value;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } seq_state_e;

  // Tone frequency registers carry 10 bits and need a trailing data byte.
  function automatic logic is_two_byte(input logic [ADDR_W-1:0] addr);
    reg_code_e code;
    code = reg_code_e'(addr);
    return (code == REG_T1_FREQ) || (code == REG_T2_FREQ) || (code == REG_T3_FREQ);
  endfunction

  function automatic logic [BYTE_W-1:0] latch_byte(input cmd_t cmd);
    return {cmd.value[3:0], cmd.addr, LATCH_BIT};
  endfunction

  function automatic logic [BYTE_W-1:0] data_byte(input cmd_t cmd);
    return {1'b0, cmd.value[9:4], 1'b0};
  endfunction

endpackage

// File: rtl/kf76489_cmd_fifo.sv
// Command FIFO: power-of-two depth, count disambiguates full from empty.
module kf76489_cmd_fifo
  import kf76489_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   push_data,
  input  logic                   pop,
  input  logic                   flush,
  output cmd_t                   pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush overrides any push or pop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/kf76489_write_sequencer.sv
// Queues register writes and serialises them onto the KF76489 CE_N/WE_N/D_IN bus
// with programmable strobe width and recovery gap.
module kf76489_write_sequencer
  import kf76489_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [VALUE_W-1:0]          cmd_value,
  input  logic                        flush,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        CE_N,
  output logic                        WE_N,
  output logic [BYTE_W-1:0]           D_IN
);

  localparam int unsigned CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  seq_state_e        state;
  seq_state_e        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  cmd_t              fifo_out;
  logic              strobe_done;
  logic              gap_done;

  logic              pend_q;
  logic              pend_nxt;
  logic [BYTE_W-1:0] pend_byte_q;
  logic [BYTE_W-1:0] pend_byte_nxt;
  logic              ce_n_nxt;
  logic [BYTE_W-1:0] d_in_nxt;

  assign cmd_ready   = !reset && !fifo_full;
  assign busy        = (fifo_count != '0) || (state != ST_IDLE);
  assign strobe_done = (cnt == CNT_W'(STROBE_CYCLES - 1));
  assign gap_done    = (cnt == CNT_W'(GAP_CYCLES - 1));

  kf76489_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_t'{addr: cmd_addr, value: cmd_value}),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, phase counter and FIFO pop; a pending data byte always beats the queue.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (strobe_done) begin
          cnt_nxt   = '0;
          state_nxt = ST_GAP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          cnt_nxt = '0;
          if (pend_q) begin
            state_nxt = ST_STROBE;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ST_STROBE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next bus values, loaded at the same edge as the state transition.
  always_comb begin
    ce_n_nxt      = CE_N;
    d_in_nxt      = D_IN;
    pend_nxt      = pend_q;
    pend_byte_nxt = pend_byte_q;
    if (pop) begin
      ce_n_nxt      = 1'b0;
      d_in_nxt      = latch_byte(fifo_out);
      pend_nxt      = is_two_byte(fifo_out.addr);
      pend_byte_nxt = data_byte(fifo_out);
    end else if (state == ST_GAP && state_nxt == ST_STROBE) begin
      ce_n_nxt = 1'b0;
      d_in_nxt = pend_byte_q;
      pend_nxt = 1'b0;
    end else if (state == ST_STROBE && state_nxt == ST_GAP) begin
      ce_n_nxt = 1'b1;
    end else if (state == ST_GAP && state_nxt == ST_IDLE) begin
      d_in_nxt = BUS_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      CE_N        <= 1'b1;
      WE_N        <= 1'b1;
      D_IN        <= BUS_IDLE;
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
    end else begin
      CE_N        <= ce_n_nxt;
      WE_N        <= ce_n_nxt;
      D_IN        <= d_in_nxt;
      pend_q      <= pend_nxt;
      pend_byte_q <= pend_byte_nxt;
    end
  end

endmodule

// File: tb/tb_kf76489_write_sequencer.sv
// Directed bench for the KF76489 write sequencer: default timing plus a 3/2 strobe/gap instance.
module tb_kf76489_write_sequencer;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_addr;
  logic [9:0] cmd_value;
  logic       flush;
  logic       busy;
  logic [2:0] fifo_count;
  logic       ce_n;
  logic       we_n;
  logic [7:0] d_in;

  logic       v6;
  logic       ready6;
  logic [2:0] a6;
  logic [9:0] val6;
  logic       flush6;
  logic       busy6;
  logic [2:0] count6;
  logic       ce6;
  logic       we6;
  logic [7:0] d6;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic       prev_ce = 1'b1;
  int         st_cyc[$];
  logic [7:0] st_byte[$];

  kf76489_write_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_value  (cmd_value),
    .flush      (flush),
    .busy       (busy),
    .fifo_count (fifo_count),
    .CE_N       (ce_n),
    .WE_N       (we_n),
    .D_IN       (d_in)
  );

  kf76489_write_sequencer #(
    .FIFO_DEPTH    (4),
    .STROBE_CYCLES (3),
    .GAP_CYCLES    (2)
  ) dut6 (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (v6),
    .cmd_ready  (ready6),
    .cmd_addr   (a6),
    .cmd_value  (val6),
    .flush      (flush6),
    .busy       (busy6),
    .fifo_count (count6),
    .CE_N       (ce6),
    .WE_N       (we6),
    .D_IN       (d6)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Record every falling CE_N edge of the default instance: cycle and byte.
  always @(negedge clock) begin
    if (prev_ce && !ce_n) begin
      st_cyc.push_back(cyc);
      st_byte.push_back(d_in);
    end
    prev_ce = ce_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_latch(input logic [2:0] a, input logic [9:0] v);
    return {v[3:0], a, 1'b1};
  endfunction

  // Present one command from a negedge; returns the cycle number of the accepting edge.
  task automatic send(input logic [2:0] a, input logic [9:0] v, output int acc);
    int t;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_value = v;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!cmd_ready) begin
      check_eq("send_timeout", 32'd0, 32'd1);
      acc = -1;
    end else begin
      @(negedge clock);
      acc = cyc;
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clock);
      t++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic clear_log();
    st_cyc.delete();
    st_byte.delete();
  endtask

  initial begin
    int k;
    int ka;
    int kb;
    int acc0;
    logic [11:0] pat;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_value = '0;
    flush     = 1'b0;
    v6        = 1'b0;
    a6        = '0;
    val6      = '0;
    flush6    = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check_eq("rst_ce_n", 32'(ce_n), 32'd1);
    check_eq("rst_we_n", 32'(we_n), 32'd1);
    check_eq("rst_d_in", 32'(d_in), 32'hFF);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_ready_forced", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    clear_log();

    // Two-byte tone-1 frequency write
    send(3'b000, 10'h155, k);
    cmd_valid = 1'b0;
    @(negedge clock);
    check_eq("t1_latch_ce", 32'(ce_n), 32'd0);
    check_eq("t1_latch_we", 32'(we_n), 32'd0);
    check_eq("t1_latch_byte", 32'(d_in), 32'h51);
    @(negedge clock);
    check_eq("t1_gap_ce", 32'(ce_n), 32'd1);
    check_eq("t1_gap_hold", 32'(d_in), 32'h51);
    @(negedge clock);
    check_eq("t1_data_we", 32'(we_n), 32'd0);
    check_eq("t1_data_byte", 32'(d_in), 32'h2A);
    wait_idle("t1_idle");
    check_eq("t1_bus_idle", 32'(d_in), 32'hFF);
    check_eq("t1_strobes", 32'(st_cyc.size()), 32'd2);
    if (st_cyc.size() == 2) begin
      check_eq("t1_latency", 32'(st_cyc[0]), 32'(k + 1));
      check_eq("t1_spacing", 32'(st_cyc[1] - st_cyc[0]), 32'd2);
    end

    // Single-byte tone-1 attenuation write
    clear_log();
    send(3'b100, 10'h00A, k);
    cmd_valid = 1'b0;
    @(negedge clock);
    check_eq("t2_byte", 32'(d_in), 32'hA9);
    check_eq("t2_busy_strobe", 32'(busy), 32'd1);
    @(negedge clock);
    check_eq("t2_busy_gap", 32'(busy), 32'd1);
    @(negedge clock);
    check_eq("t2_busy_drop", 32'(busy), 32'd0);
    check_eq("t2_bus_idle", 32'(d_in), 32'hFF);
    repeat (4) @(negedge clock);
    check_eq("t2_strobes", 32'(st_cyc.size()), 32'd1);

    // Back-to-back one-byte writes until the FIFO fills
    clear_log();
    acc0 = 0;
    for (int i = 0; i < 8; i++) begin
      send(3'(3 + i % 5), 10'(i * 3 + 1), k);
      if (i == 0) acc0 = k;
      if (i == 6) begin
        check_eq("t3_full_count", 32'(fifo_count), 32'd4);
        check_eq("t3_full_ready", 32'(cmd_ready), 32'd0);
      end
    end
    cmd_valid = 1'b0;
    wait_idle("t3_idle");
    check_eq("t3_strobes", 32'(st_cyc.size()), 32'd8);
    if (st_cyc.size() == 8) begin
      check_eq("t3_latency", 32'(st_cyc[0]), 32'(acc0 + 1));
      for (int j = 0; j < 8; j++) begin
        check_eq($sformatf("t3_byte%0d", j), 32'(st_byte[j]),
                 32'(exp_latch(3'(3 + j % 5), 10'(j * 3 + 1))));
        if (j > 0) check_eq($sformatf("t3_space%0d", j), 32'(st_cyc[j] - st_cyc[j-1]), 32'd2);
      end
    end

    // Flush with a simultaneous push during the first latch strobe
    clear_log();
    send(3'b010, 10'h3C3, ka);
    send(3'b000, 10'h111, kb);
    cmd_addr  = 3'b001;
    cmd_value = 10'h222;
    flush     = 1'b1;
    check_eq("t4_flush_ready", 32'(cmd_ready), 32'd1);
    check_eq("t4_in_strobe", 32'(ce_n), 32'd0);
    @(negedge clock);
    flush     = 1'b0;
    cmd_valid = 1'b0;
    check_eq("t4_count_cleared", 32'(fifo_count), 32'd0);
    wait_idle("t4_idle");
    check_eq("t4_strobes", 32'(st_cyc.size()), 32'd2);
    if (st_cyc.size() == 2) begin
      check_eq("t4_latch", 32'(st_byte[0]), 32'h35);
      check_eq("t4_data", 32'(st_byte[1]), 32'h78);
      check_eq("t4_spacing", 32'(st_cyc[1] - st_cyc[0]), 32'd2);
    end
    check_eq("t4_count_end", 32'(fifo_count), 32'd0);

    // Reset taken during a latch strobe
    clear_log();
    send(3'b001, 10'h2F0, k);
    cmd_valid = 1'b0;
    @(negedge clock);
    check_eq("t5_latch_ce", 32'(ce_n), 32'd0);
    check_eq("t5_latch_byte", 32'(d_in), 32'h03);
    reset = 1'b1;
    @(negedge clock);
    check_eq("t5_rst_ce", 32'(ce_n), 32'd1);
    check_eq("t5_rst_we", 32'(we_n), 32'd1);
    check_eq("t5_rst_d", 32'(d_in), 32'hFF);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check_eq("t5_strobes", 32'(st_cyc.size()), 32'd1);
    check_eq("t5_busy", 32'(busy), 32'd0);

    // 3-cycle strobe, 2-cycle gap
    check_eq("t6_ready", 32'(ready6), 32'd1);
    v6   = 1'b1;
    a6   = 3'b000;
    val6 = 10'h155;
    @(negedge clock);
    v6  = 1'b0;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      pat[11 - i] = we6;
      if (i == 0) check_eq("t6_latch", 32'(d6), 32'h51);
      if (i == 5) check_eq("t6_data", 32'(d6), 32'h2A);
    end
    check_eq("t6_we_pattern", 32'(pat), 32'h18F);
    check_eq("t6_bus_idle", 32'(d6), 32'hFF);
    check_eq("t6_busy", 32'(busy6), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
